// File: rtl/fifo_param_bcd.sv
// fifo_param_bcd: parameterised FIFO with edge-detected requests, status flags and BCD fill-level readout
module fifo_param_bcd #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 9,
  parameter int EDGE_REQ = 1,
  parameter int AF_LEVEL = 448,
  parameter int AE_LEVEL = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              rdreq,
  input  logic              wrreq,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic [ADDR_W:0]   usedw,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              data_ready,
  output logic              overflow,
  output logic              underflow,
  output logic [15:0]       bcd,
  output logic              bcd_valid
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wptr, rptr;
  logic rdreq_d, wrreq_d, rd_pulse, wr_pulse, rd_acc, wr_acc;
  logic [1:0] state;
  logic [3:0] cnt;
  logic [ADDR_W:0] sh, last_conv;
  logic [15:0] scr, adj;
  assign rd_pulse = EDGE_REQ != 0 ? rdreq & ~rdreq_d : rdreq;
  assign wr_pulse = EDGE_REQ != 0 ? wrreq & ~wrreq_d : wrreq;
  assign empty = usedw == '0;
  assign full = usedw == DEPTH;
  assign almost_empty = usedw <= (ADDR_W+1)'(AE_LEVEL);
  assign almost_full = usedw >= (ADDR_W+1)'(AF_LEVEL);
  assign data_ready = !empty && !full;
  assign rd_acc = rd_pulse && !empty;
  assign wr_acc = wr_pulse && (!full || rd_acc);
  for (genvar d = 0; d < 4; d++) begin : g_adj
    assign adj[4*d+:4] = scr[4*d+:4] >= 4'd5 ? scr[4*d+:4] + 4'd3 : scr[4*d+:4];
  end
  // request edge history and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      rdreq_d   <= 1'b0;
      wrreq_d   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rdreq_d   <= rdreq;
      wrreq_d   <= wrreq;
      overflow  <= overflow | (wr_pulse & ~wr_acc);
      underflow <= underflow | (rd_pulse & ~rd_acc);
    end
  end
  // storage array; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) mem[wptr] <= data;
  end
  // pointers, occupancy and registered read port
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      usedw   <= '0;
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      wptr    <= wptr + ADDR_W'(wr_acc);
      rptr    <= rptr + ADDR_W'(rd_acc);
      usedw   <= usedw + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
      q_valid <= rd_acc;
      if (rd_acc) q <= mem[rptr];
    end
  end
  // double-dabble conversion of the fill level, published only when complete
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      last_conv <= '0;
      scr       <= '0;
      bcd       <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      if (state == IDLE && usedw != last_conv) begin
        sh        <= usedw;
        last_conv <= usedw;
        scr       <= '0;
        cnt       <= '0;
        state     <= SHIFT;
      end else if (state == SHIFT) begin
        scr   <= {adj[14:0], sh[ADDR_W]};
        sh    <= sh << 1;
        cnt   <= cnt + 4'd1;
        state <= cnt == 4'(ADDR_W) ? DONE : SHIFT;
      end else if (state == DONE) begin
        bcd       <= scr;
        bcd_valid <= 1'b1;
        state     <= IDLE;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_fifo_param_bcd.sv
// tb_fifo_param_bcd: scoreboard bench for fifo_param_bcd in edge and level request modes
module tb_fifo_param_bcd;
  localparam int DEPTH = 512;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] data = '0;
  logic rdreq = 1'b0, wrreq = 1'b0, wrreq2 = 1'b0, rdreq2 = 1'b0;
  logic [3:0] q, q2;
  logic q_valid, q_valid2, empty, empty2, full, full2, almost_empty, almost_empty2;
  logic almost_full, almost_full2, data_ready, data_ready2, overflow, overflow2;
  logic underflow, underflow2, bcd_valid, bcd_valid2;
  logic [9:0] usedw, usedw2;
  logic [15:0] bcd, bcd2;
  logic [3:0] sb [$];
  int vectors = 0, miscompares = 0, mcnt = 0, qv_cnt = 0, bv_cnt = 0, n;
  bit m_ovf = 0, m_unf = 0;

  fifo_param_bcd #(.EDGE_REQ(1)) dut (
    .clk(clk), .reset(reset), .data(data), .rdreq(rdreq), .wrreq(wrreq),
    .q(q), .q_valid(q_valid), .usedw(usedw), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .data_ready(data_ready),
    .overflow(overflow), .underflow(underflow), .bcd(bcd), .bcd_valid(bcd_valid)
  );
  fifo_param_bcd #(.EDGE_REQ(0)) dut_lvl (
    .clk(clk), .reset(reset), .data(data), .rdreq(rdreq2), .wrreq(wrreq2),
    .q(q2), .q_valid(q_valid2), .usedw(usedw2), .empty(empty2), .full(full2),
    .almost_empty(almost_empty2), .almost_full(almost_full2), .data_ready(data_ready2),
    .overflow(overflow2), .underflow(underflow2), .bcd(bcd2), .bcd_valid(bcd_valid2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input bit w, input bit r, input logic [3:0] d);
    bit ra, wa;
    ra = r && mcnt != 0;
    wa = w && (mcnt < DEPTH || ra);
    if (w && !wa) m_ovf = 1;
    if (r && !ra) m_unf = 1;
    if (wa) sb.push_back(d);
    mcnt = mcnt + int'(wa) - int'(ra);
    data = d;
    wrreq = w;
    rdreq = r;
    tick;
    wrreq = 0;
    rdreq = 0;
    tick;
  endtask

  always @(negedge clk) begin
    if (bcd_valid) bv_cnt++;
    if (q_valid) begin
      qv_cnt++;
      if (sb.size() == 0) check("q_spurious", 1, 0);
      else check("q", q, sb.pop_front());
    end
  end

  initial begin
    repeat (2) tick;
    reset = 0;
    check("rst_usedw", usedw, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ready", data_ready, 0);
    check("rst_q", q, 0);
    check("rst_qv", q_valid, 0);
    check("rst_flags", {overflow, underflow}, 0);
    check("rst_bcd", bcd, 0);
    check("rst_bv", bcd_valid, 0);

    op(1, 0, 4'hA); op(1, 0, 4'h5); op(1, 0, 4'hF);
    check("usedw3", usedw, 3);
    check("ready3", data_ready, 1);
    n = bv_cnt;
    repeat (30) tick;
    check("bcd3", bcd, 16'h0003);
    check("bv_seen", bv_cnt > n, 1);
    repeat (3) op(0, 1, 0);
    check("empty_after", empty, 1);
    repeat (30) tick;
    check("bcd0", bcd, 0);

    data = 4'h3; wrreq = 1; sb.push_back(4'h3); mcnt++;
    tick;
    wrreq = 0;
    n = 0;
    while (!bcd_valid && n < 40) begin tick; n++; end
    check("bcd_lat", n, 12);
    check("bcd1", bcd, 1);

    data = 4'h7; wrreq = 1; wrreq2 = 1; sb.push_back(4'h7); mcnt++;
    repeat (20) tick;
    wrreq = 0; wrreq2 = 0;
    tick;
    check("hold_edge", usedw, mcnt);
    check("hold_level", usedw2, 20);

    while (mcnt < DEPTH) begin
      op(1, 0, 4'($urandom));
      if (mcnt == 447 || mcnt == 448) check("af_fill", almost_full, mcnt >= 448);
      if (mcnt == 64 || mcnt == 65) check("ae_fill", almost_empty, mcnt <= 64);
    end
    check("full", full, 1);
    check("ready_full", data_ready, 0);
    repeat (30) tick;
    check("bcd512", bcd, 16'h0512);
    check("ovf_pre", overflow, 0);
    op(1, 0, 4'h1);
    check("ovf", overflow, m_ovf);
    check("usedw_ovf", usedw, DEPTH);
    op(1, 1, 4'h2);
    check("usedw_rw_full", usedw, DEPTH);

    while (mcnt > 0) begin
      op(0, 1, 0);
      if (mcnt == 447 || mcnt == 448) check("af_drain", almost_full, mcnt >= 448);
      if (mcnt == 64 || mcnt == 65) check("ae_drain", almost_empty, mcnt <= 64);
    end
    check("unf_pre", underflow, 0);
    n = qv_cnt;
    op(0, 1, 0);
    check("qv_empty", qv_cnt, n);
    check("unf", underflow, m_unf);
    check("usedw_unf", usedw, 0);
    op(1, 1, 4'h6);
    check("usedw_rw_empty", usedw, 1);
    check("unf_rw", underflow, 1);

    for (int i = 0; i < 600; i++) begin
      op(1, 0, 4'($urandom));
      op(0, 1, 0);
    end
    while (mcnt > 0) op(0, 1, 0);
    check("usedw_wrap", usedw, 0);
    check("ae_wrap", almost_empty, 1);

    while (mcnt < 300) op(1, 0, 4'($urandom));
    repeat (3) tick;
    reset = 1; sb.delete(); mcnt = 0; m_ovf = 0; m_unf = 0;
    tick;
    check("mid_usedw", usedw, 0);
    check("mid_bcd", bcd, 0);
    check("mid_bv", bcd_valid, 0);
    check("mid_flags", {overflow, underflow}, 0);
    data = 4'h9; wrreq = 1;
    tick;
    reset = 0;
    n = bv_cnt;
    sb.push_back(4'h9); mcnt = 1;
    tick;
    wrreq = 0;
    tick;
    check("rel_edge", usedw, 1);
    op(0, 1, 0);
    check("rel_empty", empty, 1);
    repeat (4) tick;
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
